// File: rtl/atc_runway_scheduler.sv
// atc_runway_scheduler: clocked runway/gate scheduler for one landing or
// takeoff request at a time. It uses a valid/ready request handshake and a
// valid/ready grant handshake. There are N normal runways plus emergency
// runway 0. Each runway has an occupancy timer, and each normal runway has a
// round-robin gate pointer. Weather and fuel holds count down in a timer.
// Optional build macro: ATC_STATS_EN adds saturating 16-bit stat_* counters.
module atc_runway_scheduler #(
   parameter int NUM_RUNWAYS   = 2,
   parameter int GATES_PER_RWY = 3,
   parameter int OCC_CYCLES    = 8,
   parameter int WX_HOLD       = 12,
   parameter int FUEL_HOLD     = 15,
   parameter int TO_HOLD       = 15,
   localparam int RW        = $clog2(NUM_RUNWAYS + 1),
   localparam int NUM_GATES = NUM_RUNWAYS * GATES_PER_RWY,
   localparam int GW        = $clog2(NUM_GATES + 1),
   localparam int MAX_HOLD  = (WX_HOLD > FUEL_HOLD) ? ((WX_HOLD > TO_HOLD) ? WX_HOLD : TO_HOLD)
                                                   : ((FUEL_HOLD > TO_HOLD) ? FUEL_HOLD : TO_HOLD),
   localparam int TW        = ($clog2(MAX_HOLD + 1) > 4) ? $clog2(MAX_HOLD + 1) : 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_takeoff,
   input  logic                   req_emergency,
   input  logic                   req_weather,
   input  logic                   req_speed,
   input  logic                   req_range,
   input  logic                   req_altitude,
   input  logic [1:0]             req_fuel,
   input  logic [GW-1:0]          req_gate,
   output logic                   grant_valid,
   input  logic                   grant_ready,
   output logic [RW-1:0]          grant_runway,
   output logic [GW-1:0]          grant_gate,
   output logic                   grant_reject,
   output logic                   timer_active,
   output logic [TW-1:0]          timer_value,
   output logic [NUM_RUNWAYS:0]   runway_busy
`ifdef ATC_STATS_EN
   ,
   output logic [15:0]            stat_grants,
   output logic [15:0]            stat_emergencies,
   output logic [15:0]            stat_holds,
   output logic [15:0]            stat_rejects
`endif
);

   localparam int OW = ($clog2(OCC_CYCLES + 1) > 1) ? $clog2(OCC_CYCLES + 1) : 1;

   typedef enum logic [2:0] {S_IDLE, S_EVAL, S_HOLD, S_WAIT_RWY, S_GRANT} state_t;

   state_t        state_q;
   logic          req_ready_q, grant_valid_q, grant_reject_q, timer_active_q;
   logic [RW-1:0] grant_runway_q, tgt_rwy_q;
   logic [GW-1:0] grant_gate_q, gate_q;
   logic [TW-1:0] timer_value_q;
   logic          tko_q, emerg_q, wx_q, spd_q, rng_q, alt_q, any_rwy_q;
   logic [1:0]    fuel_q;

   logic          fuel_norm, grant_fire;
   logic [RW-1:0] lo_rwy, to_rwy;
   logic [GW-1:0] lo_gate;
   logic          lo_found, to_gate_ok, tgt_busy;
   logic [GW-1:0] gate_ptr [1:NUM_RUNWAYS];

   assign fuel_norm  = (fuel_q == 2'b01) || (fuel_q == 2'b10);
   assign grant_fire = grant_valid_q && grant_ready;

   // Lowest-index free normal runway and the gate its pointer offers
   always_comb begin
      lo_rwy   = '0;
      lo_found = 1'b0;
      lo_gate  = '0;
      for (int r = NUM_RUNWAYS; r >= 1; r--) begin
         if (!runway_busy[r]) begin
            lo_rwy   = RW'(r);
            lo_found = 1'b1;
            lo_gate  = gate_ptr[r];
         end
      end
   end

   // Takeoff: map the departing gate to the runway that owns it
   always_comb begin
      to_rwy     = '0;
      to_gate_ok = 1'b0;
      for (int r = 1; r <= NUM_RUNWAYS; r++) begin
         if ((gate_q >= GW'((r - 1) * GATES_PER_RWY + 1)) && (gate_q <= GW'(r * GATES_PER_RWY))) begin
            to_rwy     = RW'(r);
            to_gate_ok = 1'b1;
         end
      end
   end

   // Occupancy of the fixed target runway (emergency or takeoff)
   always_comb begin
      tgt_busy = 1'b0;
      for (int r = 0; r <= NUM_RUNWAYS; r++) begin
         if (tgt_rwy_q == RW'(r)) tgt_busy = runway_busy[r];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi <= NUM_RUNWAYS; gi++) begin : g_occ
         logic [OW-1:0] occ_q;
         logic          load;
         assign load = grant_fire && !grant_reject_q && (grant_runway_q == RW'(gi));
         // Count down occupancy; a grant on this runway reloads the counter
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)             occ_q <= '0;
            else if (load)          occ_q <= OW'(OCC_CYCLES);
            else if (occ_q != '0)   occ_q <= occ_q - 1'b1;
         end
         assign runway_busy[gi] = (occ_q != '0);
      end

      for (gi = 1; gi <= NUM_RUNWAYS; gi++) begin : g_gate
         localparam logic [GW-1:0] FIRST = GW'((gi - 1) * GATES_PER_RWY + 1);
         localparam logic [GW-1:0] LAST  = GW'(gi * GATES_PER_RWY);
         logic [GW-1:0] ptr_q, ptr_d;
         logic          adv;
         assign adv   = grant_fire && !grant_reject_q && !tko_q && (grant_runway_q == RW'(gi));
         assign ptr_d = (ptr_q == LAST) ? FIRST : ptr_q + 1'b1;
         // Round-robin gate pointer, advanced only by a landing on this runway
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   ptr_q <= FIRST;
            else if (adv) ptr_q <= ptr_d;
         end
         assign gate_ptr[gi] = ptr_q;
      end
   endgenerate

   // Request scheduler FSM with registered handshake, grant and timer outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         req_ready_q    <= 1'b0;
         grant_valid_q  <= 1'b0;
         grant_reject_q <= 1'b0;
         grant_runway_q <= '0;
         grant_gate_q   <= '0;
         timer_active_q <= 1'b0;
         timer_value_q  <= '0;
         tgt_rwy_q      <= '0;
         any_rwy_q      <= 1'b0;
         gate_q         <= '0;
         fuel_q         <= '0;
         {tko_q, emerg_q, wx_q, spd_q, rng_q, alt_q} <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               req_ready_q <= 1'b1;
               if (req_valid && req_ready_q) begin
                  tko_q       <= req_takeoff;
                  emerg_q     <= req_emergency;
                  wx_q        <= req_weather;
                  spd_q       <= req_speed;
                  rng_q       <= req_range;
                  alt_q       <= req_altitude;
                  fuel_q      <= req_fuel;
                  gate_q      <= req_gate;
                  req_ready_q <= 1'b0;
                  state_q     <= S_EVAL;
               end
            end
            S_EVAL: begin
               any_rwy_q <= 1'b0;
               tgt_rwy_q <= '0;
               if (!tko_q) begin
                  if (emerg_q || (fuel_q == 2'b00)) begin
                     state_q <= S_WAIT_RWY;
                  end else if (wx_q && spd_q && rng_q && alt_q && fuel_norm) begin
                     any_rwy_q <= 1'b1;
                     state_q   <= S_WAIT_RWY;
                  end else if (!wx_q) begin
                     any_rwy_q <= 1'b1;
                     if (WX_HOLD == 0) state_q <= S_WAIT_RWY;
                     else begin
                        state_q        <= S_HOLD;
                        timer_active_q <= 1'b1;
                        timer_value_q  <= TW'(WX_HOLD);
                     end
                  end else if (fuel_q == 2'b11) begin
                     any_rwy_q <= 1'b1;
                     if (FUEL_HOLD == 0) state_q <= S_WAIT_RWY;
                     else begin
                        state_q        <= S_HOLD;
                        timer_active_q <= 1'b1;
                        timer_value_q  <= TW'(FUEL_HOLD);
                     end
                  end else begin
                     state_q        <= S_GRANT;
                     grant_valid_q  <= 1'b1;
                     grant_reject_q <= 1'b1;
                     grant_runway_q <= '0;
                     grant_gate_q   <= '0;
                  end
               end else if (!to_gate_ok) begin
                  state_q        <= S_GRANT;
                  grant_valid_q  <= 1'b1;
                  grant_reject_q <= 1'b1;
                  grant_runway_q <= '0;
                  grant_gate_q   <= '0;
               end else begin
                  tgt_rwy_q <= to_rwy;
                  if (!wx_q && (TO_HOLD != 0)) begin
                     state_q        <= S_HOLD;
                     timer_active_q <= 1'b1;
                     timer_value_q  <= TW'(TO_HOLD);
                  end else begin
                     state_q <= S_WAIT_RWY;
                  end
               end
            end
            S_HOLD: begin
               if (timer_value_q <= TW'(1)) begin
                  timer_value_q  <= '0;
                  timer_active_q <= 1'b0;
                  state_q        <= S_WAIT_RWY;
               end else begin
                  timer_value_q <= timer_value_q - 1'b1;
               end
            end
            S_WAIT_RWY: begin
               if (any_rwy_q) begin
                  if (lo_found) begin
                     state_q        <= S_GRANT;
                     grant_valid_q  <= 1'b1;
                     grant_reject_q <= 1'b0;
                     grant_runway_q <= lo_rwy;
                     grant_gate_q   <= lo_gate;
                  end
               end else if (!tgt_busy) begin
                  state_q        <= S_GRANT;
                  grant_valid_q  <= 1'b1;
                  grant_reject_q <= 1'b0;
                  grant_runway_q <= tgt_rwy_q;
                  grant_gate_q   <= tko_q ? gate_q : '0;
               end
            end
            S_GRANT: begin
               if (grant_ready) begin
                  grant_valid_q  <= 1'b0;
                  grant_reject_q <= 1'b0;
                  grant_runway_q <= '0;
                  grant_gate_q   <= '0;
                  req_ready_q    <= 1'b1;
                  state_q        <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready    = req_ready_q;
   assign grant_valid  = grant_valid_q;
   assign grant_runway = grant_runway_q;
   assign grant_gate   = grant_gate_q;
   assign grant_reject = grant_reject_q;
   assign timer_active = timer_active_q;
   assign timer_value  = timer_value_q;

`ifdef ATC_STATS_EN
   logic [15:0] st_grants_q, st_emerg_q, st_holds_q, st_rejects_q;
   logic        hold_prev_q;

   // Saturating event counters: grant outcomes on handshake, holds on entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_grants_q  <= '0;
         st_emerg_q   <= '0;
         st_holds_q   <= '0;
         st_rejects_q <= '0;
         hold_prev_q  <= 1'b0;
      end else begin
         hold_prev_q <= timer_active_q;
         if (grant_fire && !grant_reject_q && (st_grants_q != 16'hFFFF))
            st_grants_q <= st_grants_q + 16'd1;
         if (grant_fire && !grant_reject_q && (grant_runway_q == '0) && (st_emerg_q != 16'hFFFF))
            st_emerg_q <= st_emerg_q + 16'd1;
         if (grant_fire && grant_reject_q && (st_rejects_q != 16'hFFFF))
            st_rejects_q <= st_rejects_q + 16'd1;
         if (timer_active_q && !hold_prev_q && (st_holds_q != 16'hFFFF))
            st_holds_q <= st_holds_q + 16'd1;
      end
   end

   assign stat_grants      = st_grants_q;
   assign stat_emergencies = st_emerg_q;
   assign stat_holds       = st_holds_q;
   assign stat_rejects     = st_rejects_q;
`endif

endmodule

// File: tb/tb_atc_runway_scheduler.sv
// tb_atc_runway_scheduler: directed self-checking bench for the runway scheduler.
module tb_atc_runway_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req_valid = 1'b0, req_takeoff = 1'b0, req_emergency = 1'b0;
   logic       req_weather = 1'b0, req_speed = 1'b0, req_range = 1'b0, req_altitude = 1'b0;
   logic [1:0] req_fuel = 2'b00;
   logic [2:0] req_gate = 3'd0;
   logic       grant_ready = 1'b0;
   logic       req_ready, grant_valid, grant_reject, timer_active;
   logic [1:0] grant_runway;
   logic [2:0] grant_gate;
   logic [3:0] timer_value;
   logic [2:0] runway_busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   atc_runway_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_takeoff   (req_takeoff),
      .req_emergency (req_emergency),
      .req_weather   (req_weather),
      .req_speed     (req_speed),
      .req_range     (req_range),
      .req_altitude  (req_altitude),
      .req_fuel      (req_fuel),
      .req_gate      (req_gate),
      .grant_valid   (grant_valid),
      .grant_ready   (grant_ready),
      .grant_runway  (grant_runway),
      .grant_gate    (grant_gate),
      .grant_reject  (grant_reject),
      .timer_active  (timer_active),
      .timer_value   (timer_value),
      .runway_busy   (runway_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req_valid = 1'b0;
      grant_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic set_req(input logic tko, emerg, wx, spd, rng, alt,
                          input logic [1:0] fuel, input logic [2:0] gate);
      req_takeoff = tko; req_emergency = emerg; req_weather = wx;
      req_speed = spd; req_range = rng; req_altitude = alt;
      req_fuel = fuel; req_gate = gate;
   endtask

   // Issue one request and wait for its grant; n_acc = edges to acceptance,
   // lat = edges from acceptance to grant_valid
   task automatic do_request(input logic tko, emerg, wx, spd, rng, alt,
                             input logic [1:0] fuel, input logic [2:0] gate,
                             output int n_acc, output int lat,
                             output logic [1:0] rwy, output logic [2:0] g, output logic rej);
      logic acc = 1'b0;
      n_acc = 0; lat = 0; rwy = '0; g = '0; rej = 1'b0;
      set_req(tko, emerg, wx, spd, rng, alt, fuel, gate);
      req_valid = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         acc = req_ready;
         tick();
         n_acc = i;
         if (acc) break;
      end
      req_valid = 1'b0;
      if (!acc) begin
         n_checks++; n_fail++;
         $display("FAIL accept_timeout: req_ready=%b after 60 cycles, required 1", req_ready);
         return;
      end
      for (int i = 1; i <= 60; i++) begin
         tick();
         lat = i;
         if (grant_valid) break;
      end
      if (!grant_valid) begin
         n_checks++; n_fail++;
         $display("FAIL grant_timeout: grant_valid=%b after 60 cycles, required 1", grant_valid);
         return;
      end
      rwy = grant_runway; g = grant_gate; rej = grant_reject;
      $display("txn: takeoff=%0d emerg=%0d gate_in=%0d -> runway=%0d gate=%0d reject=%0d accept_wait=%0d latency=%0d",
               tko, emerg, gate, rwy, g, rej, n_acc, lat);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      n_checks++;
      if ({req_ready, grant_valid, grant_reject, timer_active, grant_runway, grant_gate, timer_value, runway_busy} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ready=%b gv=%b rej=%b ta=%b rwy=%0d gate=%0d tv=%0d busy=%b, required all 0",
                  req_ready, grant_valid, grant_reject, timer_active, grant_runway, grant_gate, timer_value, runway_busy);
      end
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got req_ready=%b, required 1", req_ready);
      end
   endtask

   task automatic test_optimal_landing();
      int na, lt; logic [1:0] rw; logic [2:0] gt; logic rj;
      apply_reset();
      do_request(0, 0, 1, 1, 1, 1, 2'b01, 3'd0, na, lt, rw, gt, rj);
      n_checks++;
      if (lt !== 2) begin
         n_fail++; $display("FAIL opt_latency: got %0d edges, required 2", lt);
      end
      n_checks++;
      if ({rw, gt, rj} !== {2'd1, 3'd1, 1'b0}) begin
         n_fail++; $display("FAIL opt_grant: got rwy=%0d gate=%0d rej=%b, required rwy=1 gate=1 rej=0", rw, gt, rj);
      end
      tick(); tick();
      n_checks++;
      if ({grant_valid, grant_runway, grant_gate} !== {1'b1, 2'd1, 3'd1}) begin
         n_fail++; $display("FAIL opt_hold_stable: got gv=%b rwy=%0d gate=%0d, required gv=1 rwy=1 gate=1",
                            grant_valid, grant_runway, grant_gate);
      end
      grant_ready = 1'b1;
      tick();
      grant_ready = 1'b0;
      n_checks++;
      if (grant_valid !== 1'b0) begin
         n_fail++; $display("FAIL opt_handshake: got grant_valid=%b, required 0", grant_valid);
      end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (runway_busy !== 3'b010) begin
            n_fail++; $display("FAIL opt_busy[%0d]: got %b, required 010", i, runway_busy);
         end
         tick();
      end
      n_checks++;
      if (runway_busy !== 3'b000) begin
         n_fail++; $display("FAIL opt_busy_clear: got %b, required 000", runway_busy);
      end
   endtask

   task automatic test_back_to_back();
      int na, lt; logic [1:0] rw; logic [2:0] gt; logic rj;
      int exp_rwy [4] = '{1, 2, 1, 2};
      int exp_gate[4] = '{1, 4, 2, 5};
      int exp_lat [4] = '{2, 2, 4, 2};
      int exp_acc [4] = '{1, 2, 2, 2};
      apply_reset();
      grant_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         do_request(0, 0, 1, 1, 1, 1, 2'b10, 3'd0, na, lt, rw, gt, rj);
         n_checks++;
         if ((int'(rw) != exp_rwy[k]) || (int'(gt) != exp_gate[k]) || (rj !== 1'b0)) begin
            n_fail++; $display("FAIL b2b_grant[%0d]: got rwy=%0d gate=%0d rej=%b, required rwy=%0d gate=%0d rej=0",
                               k, rw, gt, rj, exp_rwy[k], exp_gate[k]);
         end
         n_checks++;
         if ((lt != exp_lat[k]) || (na != exp_acc[k])) begin
            n_fail++; $display("FAIL b2b_timing[%0d]: got accept_wait=%0d latency=%0d, required accept_wait=%0d latency=%0d",
                               k, na, lt, exp_acc[k], exp_lat[k]);
         end
      end
      tick();
      grant_ready = 1'b0;
   endtask

   task automatic test_weather_hold();
      apply_reset();
      set_req(0, 0, 0, 1, 1, 1, 2'b01, 3'd0);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      for (int k = 12; k >= 1; k--) begin
         n_checks++;
         if ((timer_active !== 1'b1) || (int'(timer_value) != k)) begin
            n_fail++; $display("FAIL wx_timer: got active=%b value=%0d, required active=1 value=%0d",
                               timer_active, timer_value, k);
         end
         tick();
      end
      n_checks++;
      if ({timer_active, timer_value, grant_valid} !== 6'b0) begin
         n_fail++; $display("FAIL wx_timer_end: got active=%b value=%0d gv=%b, required 0 0 0",
                            timer_active, timer_value, grant_valid);
      end
      tick();
      n_checks++;
      if ({grant_valid, grant_runway, grant_gate, grant_reject} !== {1'b1, 2'd1, 3'd1, 1'b0}) begin
         n_fail++; $display("FAIL wx_grant: got gv=%b rwy=%0d gate=%0d rej=%b, required gv=1 rwy=1 gate=1 rej=0",
                            grant_valid, grant_runway, grant_gate, grant_reject);
      end
      grant_ready = 1'b1;
      tick();
      grant_ready = 1'b0;
   endtask

   task automatic test_fuel_hold();
      int na, lt; logic [1:0] rw; logic [2:0] gt; logic rj;
      apply_reset();
      grant_ready = 1'b1;
      do_request(0, 0, 1, 1, 1, 1, 2'b11, 3'd0, na, lt, rw, gt, rj);
      n_checks++;
      if (lt != 17) begin
         n_fail++; $display("FAIL fuel_latency: got %0d edges, required 17", lt);
      end
      n_checks++;
      if ({rw, gt, rj} !== {2'd1, 3'd1, 1'b0}) begin
         n_fail++; $display("FAIL fuel_grant: got rwy=%0d gate=%0d rej=%b, required rwy=1 gate=1 rej=0", rw, gt, rj);
      end
      tick();
   endtask

   task automatic test_emergency();
      int na, lt; logic [1:0] rw; logic [2:0] gt; logic rj;
      apply_reset();
      grant_ready = 1'b1;
      do_request(0, 0, 1, 1, 1, 1, 2'b01, 3'd0, na, lt, rw, gt, rj);
      do_request(0, 0, 1, 1, 1, 1, 2'b01, 3'd0, na, lt, rw, gt, rj);
      do_request(0, 1, 1, 1, 1, 1, 2'b01, 3'd0, na, lt, rw, gt, rj);
      n_checks++;
      if (runway_busy !== 3'b110) begin
         n_fail++; $display("FAIL emerg_busy: got %b, required 110", runway_busy);
      end
      n_checks++;
      if ({rw, gt, rj} !== {2'd0, 3'd0, 1'b0} || lt != 2) begin
         n_fail++; $display("FAIL emerg_grant: got rwy=%0d gate=%0d rej=%b lat=%0d, required rwy=0 gate=0 rej=0 lat=2",
                            rw, gt, rj, lt);
      end
      tick();
      n_checks++;
      if (runway_busy[0] !== 1'b1) begin
         n_fail++; $display("FAIL emerg_occupy: got busy=%b, required bit0 set", runway_busy);
      end
   endtask

   task automatic test_takeoff();
      int na, lt; logic [1:0] rw; logic [2:0] gt; logic rj;
      apply_reset();
      grant_ready = 1'b1;
      do_request(1, 0, 0, 1, 1, 1, 2'b01, 3'd5, na, lt, rw, gt, rj);
      n_checks++;
      if ({rw, gt, rj} !== {2'd2, 3'd5, 1'b0} || lt != 17) begin
         n_fail++; $display("FAIL to_hold_grant: got rwy=%0d gate=%0d rej=%b lat=%0d, required rwy=2 gate=5 rej=0 lat=17",
                            rw, gt, rj, lt);
      end
      tick();
      n_checks++;
      if (runway_busy !== 3'b100) begin
         n_fail++; $display("FAIL to_busy: got %b, required 100", runway_busy);
      end
      do_request(1, 0, 1, 1, 1, 1, 2'b01, 3'd7, na, lt, rw, gt, rj);
      n_checks++;
      if ({rw, gt, rj} !== {2'd0, 3'd0, 1'b1} || lt != 1) begin
         n_fail++; $display("FAIL to_gate7_reject: got rwy=%0d gate=%0d rej=%b lat=%0d, required rwy=0 gate=0 rej=1 lat=1",
                            rw, gt, rj, lt);
      end
      tick();
      n_checks++;
      if (runway_busy !== 3'b100) begin
         n_fail++; $display("FAIL to_reject_no_load: got %b, required 100", runway_busy);
      end
      do_request(1, 0, 1, 1, 1, 1, 2'b01, 3'd0, na, lt, rw, gt, rj);
      n_checks++;
      if ({rw, gt, rj} !== {2'd0, 3'd0, 1'b1}) begin
         n_fail++; $display("FAIL to_gate0_reject: got rwy=%0d gate=%0d rej=%b, required rwy=0 gate=0 rej=1", rw, gt, rj);
      end
      tick();
      do_request(1, 0, 1, 1, 1, 1, 2'b01, 3'd2, na, lt, rw, gt, rj);
      n_checks++;
      if ({rw, gt, rj} !== {2'd1, 3'd2, 1'b0} || lt != 2) begin
         n_fail++; $display("FAIL to_gate2: got rwy=%0d gate=%0d rej=%b lat=%0d, required rwy=1 gate=2 rej=0 lat=2",
                            rw, gt, rj, lt);
      end
      tick();
   endtask

   task automatic test_classification();
      int na, lt; logic [1:0] rw; logic [2:0] gt; logic rj;
      apply_reset();
      grant_ready = 1'b1;
      do_request(0, 0, 1, 0, 1, 1, 2'b01, 3'd0, na, lt, rw, gt, rj);
      n_checks++;
      if ({rw, gt, rj} !== {2'd0, 3'd0, 1'b1} || lt != 1) begin
         n_fail++; $display("FAIL cls_speed_reject: got rwy=%0d gate=%0d rej=%b lat=%0d, required 0 0 1 lat=1", rw, gt, rj, lt);
      end
      tick();
      do_request(0, 0, 1, 1, 1, 1, 2'b00, 3'd0, na, lt, rw, gt, rj);
      n_checks++;
      if ({rw, gt, rj} !== {2'd0, 3'd0, 1'b0} || lt != 2) begin
         n_fail++; $display("FAIL cls_fuel_critical: got rwy=%0d gate=%0d rej=%b lat=%0d, required 0 0 0 lat=2", rw, gt, rj, lt);
      end
      tick();
      do_request(0, 0, 1, 1, 1, 0, 2'b11, 3'd0, na, lt, rw, gt, rj);
      n_checks++;
      if ({rw, gt, rj} !== {2'd1, 3'd1, 1'b0} || lt != 17) begin
         n_fail++; $display("FAIL cls_fuel_excess: got rwy=%0d gate=%0d rej=%b lat=%0d, required 1 1 0 lat=17", rw, gt, rj, lt);
      end
      tick();
      do_request(0, 0, 0, 0, 1, 1, 2'b01, 3'd0, na, lt, rw, gt, rj);
      n_checks++;
      if ({rw, gt, rj} !== {2'd1, 3'd2, 1'b0} || lt != 14) begin
         n_fail++; $display("FAIL cls_weather_first: got rwy=%0d gate=%0d rej=%b lat=%0d, required 1 2 0 lat=14", rw, gt, rj, lt);
      end
      tick();
   endtask

   task automatic test_gate_wrap();
      int na, lt; logic [1:0] rw; logic [2:0] gt; logic rj;
      int exp_gate[4] = '{1, 2, 3, 1};
      apply_reset();
      grant_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         do_request(0, 0, 1, 1, 1, 1, 2'b01, 3'd0, na, lt, rw, gt, rj);
         n_checks++;
         if ((rw !== 2'd1) || (int'(gt) != exp_gate[k])) begin
            n_fail++; $display("FAIL wrap_gate[%0d]: got rwy=%0d gate=%0d, required rwy=1 gate=%0d", k, rw, gt, exp_gate[k]);
         end
         tick();
         repeat (10) tick();
      end
   endtask

   task automatic test_reset_in_hold();
      int na, lt; logic [1:0] rw; logic [2:0] gt; logic rj;
      apply_reset();
      grant_ready = 1'b1;
      do_request(0, 0, 1, 1, 1, 1, 2'b01, 3'd0, na, lt, rw, gt, rj);
      tick();
      repeat (10) tick();
      set_req(0, 0, 0, 1, 1, 1, 2'b01, 3'd0);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (timer_active && (timer_value == 4'd6)) break;
         tick();
      end
      n_checks++;
      if ({timer_active, timer_value} !== {1'b1, 4'd6}) begin
         n_fail++; $display("FAIL rst_hold_reach: got active=%b value=%0d, required active=1 value=6", timer_active, timer_value);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({req_ready, grant_valid, grant_reject, timer_active, grant_runway, grant_gate, timer_value, runway_busy} !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_async_clear: got ready=%b gv=%b rej=%b ta=%b rwy=%0d gate=%0d tv=%0d busy=%b, required all 0",
                  req_ready, grant_valid, grant_reject, timer_active, grant_runway, grant_gate, timer_value, runway_busy);
      end
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_ready_after: got %b, required 1", req_ready);
      end
      do_request(0, 0, 1, 1, 1, 1, 2'b01, 3'd0, na, lt, rw, gt, rj);
      n_checks++;
      if ({rw, gt, rj} !== {2'd1, 3'd1, 1'b0}) begin
         n_fail++; $display("FAIL rst_gate_ptr: got rwy=%0d gate=%0d rej=%b, required rwy=1 gate=1 rej=0", rw, gt, rj);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_optimal_landing();
      test_back_to_back();
      test_weather_hold();
      test_fuel_hold();
      test_emergency();
      test_takeoff();
      test_classification();
      test_gate_wrap();
      test_reset_in_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time limit, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
